// File: rtl/bform_branch_prep_queue.sv
// Branch Conditional prep queue: decodes B-form bodies, precomputes target/link/CR/BO info
// and buffers results in an in-order FIFO. Optional static prediction: BRANCH_STATIC_PREDICT_EN.
module bform_branch_prep_queue #(
   parameter int addressWidth            = 64,
   parameter int instructionCounterWidth = 64,
   parameter int instMinIdWidth          = 7,
   parameter int opcodeSize              = 12,
   parameter int funcUnitCodeSize        = 3,
   parameter int PidSize                 = 20,
   parameter int TidSize                 = 16,
   parameter int bodySize                = 28,
   parameter int queueDepth              = 4,
   parameter int BranchUnitID            = 6,
   parameter int BcOpcode                = 25
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               enable_i,
   input  logic [opcodeSize-1:0]              opcode_i,
   input  logic [addressWidth-1:0]            instructionAddress_i,
   input  logic [funcUnitCodeSize-1:0]        functionalUnitType_i,
   input  logic [instructionCounterWidth-1:0] instMajId_i,
   input  logic [instMinIdWidth-1:0]          instMinId_i,
   input  logic [instMinIdWidth-1:0]          numMicroOps_i,
   input  logic                               is64Bit_i,
   input  logic [PidSize-1:0]                 instPid_i,
   input  logic [TidSize-1:0]                 instTid_i,
   input  logic [bodySize-1:0]                instructionBody_i,
   input  logic                               stall_i,
   input  logic                               flush_i,
   output logic                               stall_o,
   output logic                               enable_o,
   output logic [opcodeSize-1:0]              opcode_o,
   output logic [addressWidth-1:0]            instructionAddress_o,
   output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
   output logic [instructionCounterWidth-1:0] instMajId_o,
   output logic [instMinIdWidth-1:0]          instMinId_o,
   output logic [instMinIdWidth-1:0]          numMicroOps_o,
   output logic                               is64Bit_o,
   output logic [PidSize-1:0]                 instPid_o,
   output logic [TidSize-1:0]                 instTid_o,
   output logic [addressWidth-1:0]            branchTarget_o,
   output logic [addressWidth-1:0]            linkAddress_o,
   output logic [6:0]                         crBitIndex_o,
   output logic                               condIgnored_o,
   output logic                               condValue_o,
   output logic                               usesCtr_o,
   output logic                               ctrZeroTest_o,
   output logic                               writesLr_o,
   output logic                               alwaysTaken_o,
   output logic                               predictTaken_o,
   output logic [$clog2(queueDepth):0]        occupancy_o,
   output logic                               overflow_o
);

   localparam int PTR_W = $clog2(queueDepth);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [opcodeSize-1:0]              opcode;
      logic [addressWidth-1:0]            addr;
      logic [funcUnitCodeSize-1:0]        fu;
      logic [instructionCounterWidth-1:0] maj_id;
      logic [instMinIdWidth-1:0]          min_id;
      logic [instMinIdWidth-1:0]          num_uops;
      logic                               is64;
      logic [PidSize-1:0]                 pid;
      logic [TidSize-1:0]                 tid;
      logic [addressWidth-1:0]            target;
      logic [addressWidth-1:0]            link;
      logic [6:0]                         cr_bit;
      logic                               cond_ignored;
      logic                               cond_value;
      logic                               uses_ctr;
      logic                               ctr_zero_test;
      logic                               writes_lr;
      logic                               always_taken;
`ifdef BRANCH_STATIC_PREDICT_EN
      logic                               predict;
`endif
   } entry_t;

   entry_t                mem_q [queueDepth];
   entry_t                mem_d [queueDepth];
   logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]      occ_q, occ_d;
   logic                  stall_q, stall_d;
   logic                  ovf_q, ovf_d;

   entry_t                new_s;
   logic [4:0]            bo_s;
   logic [4:0]            bi_s;
   logic [13:0]           bd_s;
   logic                  aa_s, lk_s;
   logic [addressWidth-1:0] disp_s;
   logic                  push_s, pop_s, full_s, wr_s;

   // Body uses big-endian field numbering: bit 0 is the MSB of the 28-bit body.
   always_comb begin
      bo_s   = instructionBody_i[bodySize-1 -: 5];
      bi_s   = instructionBody_i[bodySize-6 -: 5];
      bd_s   = instructionBody_i[bodySize-11 -: 14];
      aa_s   = instructionBody_i[1];
      lk_s   = instructionBody_i[0];
      disp_s = {{(addressWidth-16){bd_s[13]}}, bd_s, 2'b00};

      new_s               = '0;
      new_s.opcode        = opcode_i;
      new_s.addr          = instructionAddress_i;
      new_s.fu            = functionalUnitType_i;
      new_s.maj_id        = instMajId_i;
      new_s.min_id        = instMinId_i;
      new_s.num_uops      = numMicroOps_i;
      new_s.is64          = is64Bit_i;
      new_s.pid           = instPid_i;
      new_s.tid           = instTid_i;
      new_s.target        = aa_s ? disp_s : (instructionAddress_i + disp_s);
      new_s.link          = instructionAddress_i + addressWidth'(4);
      if (!is64Bit_i) begin
         new_s.target[addressWidth-1:32] = '0;
         new_s.link[addressWidth-1:32]   = '0;
      end else begin
         new_s.target = new_s.target;
      end
      new_s.cr_bit        = {2'b00, bi_s} + 7'd32;
      new_s.cond_ignored  = bo_s[4];
      new_s.cond_value    = bo_s[3];
      new_s.uses_ctr      = ~bo_s[2];
      new_s.ctr_zero_test = bo_s[1];
      new_s.writes_lr     = lk_s;
      new_s.always_taken  = bo_s[4] & bo_s[2];
`ifdef BRANCH_STATIC_PREDICT_EN
      // Backward-taken / forward-not-taken for relative conditional branches.
      new_s.predict = (bo_s[4] & bo_s[2]) |
                      ((~bo_s[4] | ~bo_s[2]) & ~aa_s & disp_s[addressWidth-1]);
`endif
   end

   // Queue pointer, occupancy, overflow and back-pressure next-state.
   always_comb begin
      full_s = (occ_q == CNT_W'(queueDepth));
      push_s = enable_i && (opcode_i == opcodeSize'(BcOpcode)) &&
               (functionalUnitType_i == funcUnitCodeSize'(BranchUnitID));
      pop_s  = (occ_q != '0) && !stall_i;
      wr_s   = push_s && (!full_s || pop_s);

      mem_d  = mem_q;
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      ovf_d  = ovf_q;

      if (flush_i) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end else begin
         if (wr_s) begin
            mem_d[tail_q] = new_s;
            tail_d        = tail_q + PTR_W'(1);
         end else begin
            tail_d = tail_q;
         end
         if (pop_s) begin
            head_d = head_q + PTR_W'(1);
         end else begin
            head_d = head_q;
         end
         if (push_s && full_s && !pop_s) begin
            ovf_d = 1'b1;
         end else begin
            ovf_d = ovf_q;
         end
         case ({wr_s, pop_s})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
         endcase
      end
      // Two slots of headroom cover the packet already in flight from the decoder.
      stall_d = (occ_d >= CNT_W'(queueDepth - 2));
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int i = 0; i < queueDepth; i++) begin
            mem_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         occ_q   <= '0;
         stall_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         for (int i = 0; i < queueDepth; i++) begin
            mem_q[i] <= mem_d[i];
         end
         head_q  <= head_d;
         tail_q  <= tail_d;
         occ_q   <= occ_d;
         stall_q <= stall_d;
         ovf_q   <= ovf_d;
      end
   end

   entry_t head_e;
   assign head_e = mem_q[head_q];

   assign stall_o              = stall_q;
   assign enable_o             = (occ_q != '0);
   assign occupancy_o          = occ_q;
   assign overflow_o           = ovf_q;
   assign opcode_o             = head_e.opcode;
   assign instructionAddress_o = head_e.addr;
   assign functionalUnitType_o = head_e.fu;
   assign instMajId_o          = head_e.maj_id;
   assign instMinId_o          = head_e.min_id;
   assign numMicroOps_o        = head_e.num_uops;
   assign is64Bit_o            = head_e.is64;
   assign instPid_o            = head_e.pid;
   assign instTid_o            = head_e.tid;
   assign branchTarget_o       = head_e.target;
   assign linkAddress_o        = head_e.link;
   assign crBitIndex_o         = head_e.cr_bit;
   assign condIgnored_o        = head_e.cond_ignored;
   assign condValue_o          = head_e.cond_value;
   assign usesCtr_o            = head_e.uses_ctr;
   assign ctrZeroTest_o        = head_e.ctr_zero_test;
   assign writesLr_o           = head_e.writes_lr;
   assign alwaysTaken_o        = head_e.always_taken;
`ifdef BRANCH_STATIC_PREDICT_EN
   assign predictTaken_o       = head_e.predict;
`else
   assign predictTaken_o       = 1'b0;
`endif

endmodule

// File: tb/tb_bform_branch_prep_queue.sv
// Scoreboard bench for bform_branch_prep_queue: expected entries are queued at push
// and compared against the head when the DUT pops.
module tb_bform_branch_prep_queue;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_i, enable_i, is64Bit_i, stall_i, flush_i;
   logic [11:0] opcode_i;
   logic [63:0] instructionAddress_i, instMajId_i;
   logic [2:0]  functionalUnitType_i;
   logic [6:0]  instMinId_i, numMicroOps_i;
   logic [19:0] instPid_i;
   logic [15:0] instTid_i;
   logic [27:0] instructionBody_i;

   logic        stall_o, enable_o, is64Bit_o;
   logic [11:0] opcode_o;
   logic [63:0] instructionAddress_o, instMajId_o, branchTarget_o, linkAddress_o;
   logic [2:0]  functionalUnitType_o;
   logic [6:0]  instMinId_o, numMicroOps_o, crBitIndex_o;
   logic [19:0] instPid_o;
   logic [15:0] instTid_o;
   logic        condIgnored_o, condValue_o, usesCtr_o, ctrZeroTest_o;
   logic        writesLr_o, alwaysTaken_o, predictTaken_o, overflow_o;
   logic [2:0]  occupancy_o;

   bform_branch_prep_queue dut (
      .clock_i(clk), .reset_i(reset_i), .enable_i(enable_i), .opcode_i(opcode_i),
      .instructionAddress_i(instructionAddress_i), .functionalUnitType_i(functionalUnitType_i),
      .instMajId_i(instMajId_i), .instMinId_i(instMinId_i), .numMicroOps_i(numMicroOps_i),
      .is64Bit_i(is64Bit_i), .instPid_i(instPid_i), .instTid_i(instTid_i),
      .instructionBody_i(instructionBody_i), .stall_i(stall_i), .flush_i(flush_i),
      .stall_o(stall_o), .enable_o(enable_o), .opcode_o(opcode_o),
      .instructionAddress_o(instructionAddress_o), .functionalUnitType_o(functionalUnitType_o),
      .instMajId_o(instMajId_o), .instMinId_o(instMinId_o), .numMicroOps_o(numMicroOps_o),
      .is64Bit_o(is64Bit_o), .instPid_o(instPid_o), .instTid_o(instTid_o),
      .branchTarget_o(branchTarget_o), .linkAddress_o(linkAddress_o),
      .crBitIndex_o(crBitIndex_o), .condIgnored_o(condIgnored_o), .condValue_o(condValue_o),
      .usesCtr_o(usesCtr_o), .ctrZeroTest_o(ctrZeroTest_o), .writesLr_o(writesLr_o),
      .alwaysTaken_o(alwaysTaken_o), .predictTaken_o(predictTaken_o),
      .occupancy_o(occupancy_o), .overflow_o(overflow_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      logic [63:0] maj;
      logic [63:0] tgt;
      logic [63:0] lnk;
      logic [19:0] pid;
      logic [6:0]  cr;
      logic [5:0]  flg;
      logic        pred;
   } exp_t;

   exp_t sb[$];
   int   m_occ = 0;
   logic m_ovf = 1'b0;

   function automatic exp_t model(input logic [63:0] addr, input logic [27:0] body,
                                  input logic is64, input logic [63:0] maj, input logic [19:0] pid);
      exp_t e;
      logic [4:0]  bo, bi;
      logic [13:0] bd;
      logic        aa, lk;
      logic [15:0] d16;
      logic [63:0] disp;
      bo   = body[27:23];
      bi   = body[22:18];
      bd   = body[17:4];
      aa   = body[1];
      lk   = body[0];
      d16  = {bd, 2'b00};
      disp = {{48{d16[15]}}, d16};
      e.maj = maj;
      e.pid = pid;
      e.tgt = aa ? disp : addr + disp;
      e.lnk = addr + 64'd4;
      if (!is64) begin
         e.tgt = e.tgt & 64'h0000_0000_FFFF_FFFF;
         e.lnk = e.lnk & 64'h0000_0000_FFFF_FFFF;
      end
      e.cr  = 7'd32 + {2'b00, bi};
      e.flg = {bo[4], bo[3], ~bo[2], bo[1], lk, bo[4] & bo[2]};
`ifdef BRANCH_STATIC_PREDICT_EN
      e.pred = (bo[4] & bo[2]) | (!(bo[4] && bo[2]) && !aa && disp[63]);
`else
      e.pred = 1'b0;
`endif
      return e;
   endfunction

   // One clock: score the pop that is about to happen, update the model, then check status.
   task automatic tick();
      logic pop_m, push_m;
      exp_t e;
      pop_m  = (m_occ != 0) && !stall_i && !flush_i && !reset_i;
      push_m = enable_i && (opcode_i == 12'd25) && (functionalUnitType_i == 3'd6);
      if (pop_m) begin
         if (sb.size() == 0) begin
            check_val("sb_underflow", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check_val("majId", instMajId_o, e.maj);
            check_val("target", branchTarget_o, e.tgt);
            check_val("link", linkAddress_o, e.lnk);
            check_val("crBit", {57'd0, crBitIndex_o}, {57'd0, e.cr});
            check_val("boFlags", {58'd0, condIgnored_o, condValue_o, usesCtr_o, ctrZeroTest_o,
                      writesLr_o, alwaysTaken_o}, {58'd0, e.flg});
            check_val("predict", {63'd0, predictTaken_o}, {63'd0, e.pred});
            check_val("pid", {44'd0, instPid_o}, {44'd0, e.pid});
            check_val("opcode", {52'd0, opcode_o}, 64'd25);
         end
      end
      if (reset_i) begin
         sb.delete(); m_occ = 0; m_ovf = 1'b0;
      end else if (flush_i) begin
         sb.delete(); m_occ = 0;
      end else if (push_m && (m_occ < 4 || pop_m)) begin
         sb.push_back(model(instructionAddress_i, instructionBody_i, is64Bit_i,
                            instMajId_i, instPid_i));
         if (!pop_m) m_occ++;
      end else begin
         if (push_m) m_ovf = 1'b1;
         if (pop_m) m_occ--;
      end
      @(posedge clk);
      #1;
      check_val("occupancy", {61'd0, occupancy_o}, 64'(m_occ));
      check_val("enable_o", {63'd0, enable_o}, {63'd0, (m_occ != 0)});
      check_val("overflow", {63'd0, overflow_o}, {63'd0, m_ovf});
      check_val("stall_o", {63'd0, stall_o}, {63'd0, (m_occ >= 2)});
   endtask

   task automatic pkt(input logic [63:0] addr, input logic [4:0] bo, input logic [4:0] bi,
                      input logic [13:0] bd, input logic aa, input logic lk,
                      input logic is64, input logic [63:0] maj);
      enable_i             = 1'b1;
      opcode_i             = 12'd25;
      functionalUnitType_i = 3'd6;
      instructionAddress_i = addr;
      instructionBody_i    = {bo, bi, bd, 2'b00, aa, lk};
      is64Bit_i            = is64;
      instMajId_i          = maj;
      instPid_i            = maj[19:0] ^ 20'hA5A5A;
   endtask

   task automatic idle();
      enable_i = 1'b0;
   endtask

   task automatic drain(input int n);
      idle();
      stall_i = 1'b0;
      flush_i = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset_i = 1'b1; enable_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
      opcode_i = 12'd0; functionalUnitType_i = 3'd0; instructionAddress_i = 64'd0;
      instMajId_i = 64'd0; instMinId_i = 7'd1; numMicroOps_i = 7'd1; is64Bit_i = 1'b1;
      instPid_i = 20'd0; instTid_i = 16'd7; instructionBody_i = 28'd0;
      tick();
      tick();
      check_val("reset_target", branchTarget_o, 64'd0);
      check_val("reset_majId", instMajId_o, 64'd0);
      reset_i = 1'b0;

      // Forward branch, always taken, link.
      stall_i = 1'b1;
      pkt(64'h1000, 5'b10100, 5'd3, 14'h0004, 1'b0, 1'b1, 1'b1, 64'd10);
      tick();
      idle();
      check_val("fwd_target", branchTarget_o, 64'h1010);
      check_val("fwd_link", linkAddress_o, 64'h1004);
      check_val("fwd_cr", {57'd0, crBitIndex_o}, 64'd35);
      check_val("fwd_always", {63'd0, alwaysTaken_o}, 64'd1);
      check_val("fwd_lr", {63'd0, writesLr_o}, 64'd1);
      check_val("fwd_ctr", {63'd0, usesCtr_o}, 64'd0);
`ifdef BRANCH_STATIC_PREDICT_EN
      check_val("fwd_pred", {63'd0, predictTaken_o}, 64'd1);
`endif
      drain(2);

      // Negative displacement, relative / absolute / 32-bit.
      stall_i = 1'b1;
      pkt(64'h2000, 5'b00100, 5'd0, 14'h3FFF, 1'b0, 1'b0, 1'b1, 64'd11);
      tick(); idle();
      check_val("neg_rel_target", branchTarget_o, 64'h1FFC);
`ifdef BRANCH_STATIC_PREDICT_EN
      check_val("neg_rel_pred", {63'd0, predictTaken_o}, 64'd1);
`endif
      drain(2);
      stall_i = 1'b1;
      pkt(64'h2000, 5'b00100, 5'd0, 14'h3FFF, 1'b1, 1'b0, 1'b1, 64'd12);
      tick(); idle();
      check_val("neg_abs_target", branchTarget_o, 64'hFFFF_FFFF_FFFF_FFFC);
      drain(2);
      stall_i = 1'b1;
      pkt(64'h2000, 5'b00100, 5'd0, 14'h3FFF, 1'b1, 1'b0, 1'b0, 64'd13);
      tick(); idle();
      check_val("abs32_target", branchTarget_o, 64'h0000_0000_FFFF_FFFC);
      check_val("abs32_link", linkAddress_o, 64'h2004);
      drain(2);

      // Back-pressure with three queued packets, then in-order release.
      stall_i = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         pkt(64'h4000 + 64'(i * 16), 5'b01100, 5'(i), 14'(i), 1'b0, 1'b0, 1'b1, 64'(i));
         tick();
         if (i == 1) check_val("bp_stall_occ1", {63'd0, stall_o}, 64'd0);
         if (i == 2) check_val("bp_stall_occ2", {63'd0, stall_o}, 64'd1);
      end
      idle();
      check_val("bp_occ3", {61'd0, occupancy_o}, 64'd3);
      drain(3);
      check_val("bp_empty", {63'd0, enable_o}, 64'd0);

      // Overflow: fifth push into a stalled full queue is lost.
      stall_i = 1'b1;
      for (int i = 21; i <= 25; i++) begin
         pkt(64'h8000, 5'b10000, 5'd1, 14'h0010, 1'b0, 1'b0, 1'b1, 64'(i));
         tick();
      end
      idle();
      check_val("ovf_occ", {61'd0, occupancy_o}, 64'd4);
      check_val("ovf_flag", {63'd0, overflow_o}, 64'd1);
      drain(5);

      // Flush with a same-cycle push; overflow survives.
      stall_i = 1'b1;
      for (int i = 31; i <= 33; i++) begin
         pkt(64'hC000, 5'b00000, 5'd2, 14'h1000, 1'b0, 1'b0, 1'b1, 64'(i));
         tick();
      end
      pkt(64'hC000, 5'b00000, 5'd2, 14'h1000, 1'b0, 1'b0, 1'b1, 64'd34);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0; idle();
      check_val("flush_occ", {61'd0, occupancy_o}, 64'd0);
      check_val("flush_stall", {63'd0, stall_o}, 64'd0);
      check_val("flush_ovf_kept", {63'd0, overflow_o}, 64'd1);

      // Reset mid-operation clears overflow too.
      for (int i = 41; i <= 43; i++) begin
         pkt(64'hD000, 5'b00000, 5'd2, 14'h1000, 1'b0, 1'b0, 1'b1, 64'(i));
         tick();
      end
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0; idle();
      check_val("rst_ovf", {63'd0, overflow_o}, 64'd0);
      check_val("rst_enable", {63'd0, enable_o}, 64'd0);

      // Filtering: wrong opcode and wrong unit are dropped.
      stall_i = 1'b1;
      pkt(64'hE000, 5'b10100, 5'd0, 14'h0001, 1'b0, 1'b0, 1'b1, 64'd50);
      opcode_i = 12'd16;
      tick();
      pkt(64'hE000, 5'b10100, 5'd0, 14'h0001, 1'b0, 1'b0, 1'b1, 64'd51);
      functionalUnitType_i = 3'd0;
      tick();
      idle();
      check_val("filter_occ", {61'd0, occupancy_o}, 64'd0);

      // Full queue with simultaneous push and pop.
      for (int i = 61; i <= 64; i++) begin
         pkt(64'hF000, 5'b10100, 5'd4, 14'h0008, 1'b0, 1'b1, 1'b1, 64'(i));
         tick();
      end
      stall_i = 1'b0;
      pkt(64'hF000, 5'b10100, 5'd4, 14'h0008, 1'b0, 1'b1, 1'b1, 64'd65);
      tick();
      idle();
      check_val("full_pp_occ", {61'd0, occupancy_o}, 64'd4);
      check_val("full_pp_ovf", {63'd0, overflow_o}, 64'd0);
      drain(5);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         pkt({$urandom, $urandom}, 5'($urandom), 5'($urandom), 14'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 64'(1000 + i));
         enable_i = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) opcode_i = 12'd16;
         if ($urandom_range(0, 9) == 0) functionalUnitType_i = 3'($urandom_range(0, 5));
         stall_i = ($urandom_range(0, 2) == 0);
         flush_i = ($urandom_range(0, 49) == 0);
         tick();
      end
      drain(6);
      check_val("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
